battle_turn_ctrl: RTL and testbench

Turn sequencer for the battle simulator. It runs one full combat turn per `go`: the player attacks first, then the AI attacks. Each damage multiply is issued to the shared ALU over a req/ack handshake. The block subtracts damage from the HP registers it owns, flooring at zero, and declares victory or loss. It sits between the top-level input logic (switches/keys) and the shared arithmetic datapath.

---
 rtl/battle_turn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_battle_turn_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_turn_ctrl.sv
// Combat turn sequencer: player attack, then AI attack, each damage multiply issued to a shared ALU.
// Optional ALU-ack watchdog is enabled by defining BATTLE_ALU_TIMEOUT_EN.
module battle_turn_ctrl #(
  parameter int unsigned MAX_HP      = 100,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  input  logic [1:0]  player_move,
  input  logic [1:0]  ai_move,
  input  logic [7:0]  player_atk,
  input  logic [7:0]  ai_atk,
  output logic        alu_req,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_op,
  input  logic        alu_ack,
  input  logic [15:0] alu_result,
  output logic [7:0]  player_hp,
  output logic [7:0]  ai_hp,
  output logic        busy,
  output logic        turn_done,
  output logic        victory,
  output logic        loss,
  output logic        alu_err,
  output logic [2:0]  fsm_state
);

  // ALU handshake: alu_req rises with stable alu_a/alu_b/alu_op and holds them
  // until the cycle in which alu_ack is sampled high; alu_result is taken in that cycle.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_MUL   = 3'd1,
    P_APPLY = 3'd2,
    A_MUL   = 3'd3,
    A_APPLY = 3'd4,
    VICTORY = 3'd5,
    LOSS    = 3'd6
  } state_t;

  localparam logic [7:0] HP_INIT = 8'(MAX_HP);

  state_t      state, next_state;
  logic [1:0]  p_move, a_move;
  logic [7:0]  p_atk, a_atk;
  logic [7:0]  dmg;
  logic [12:0] dmg_raw;
  logic [7:0]  dmg_sat;
  logic [7:0]  ai_hp_new, player_hp_new;
  logic        in_mul;
  logic        timeout;
  logic        next_req;
  logic [7:0]  next_a, next_b;
  logic        unused_bits;

  function automatic logic [7:0] power(input logic [1:0] m);
    case (m)
      2'd0:    power = 8'd4;
      2'd1:    power = 8'd6;
      2'd2:    power = 8'd8;
      default: power = 8'd12;
    endcase
  endfunction

  assign in_mul    = (state == P_MUL) || (state == A_MUL);
  assign busy      = !((state == IDLE) || (state == VICTORY) || (state == LOSS));
  assign victory   = (state == VICTORY);
  assign loss      = (state == LOSS);
  assign alu_op    = alu_req;
  assign fsm_state = state;

  always_comb begin
    next_state    = state;
    dmg_raw       = alu_result[15:3];
    dmg_sat       = (|dmg_raw[12:8]) ? 8'hff : dmg_raw[7:0];
    ai_hp_new     = (ai_hp > dmg) ? (ai_hp - dmg) : 8'd0;
    player_hp_new = (player_hp > dmg) ? (player_hp - dmg) : 8'd0;
    next_req      = 1'b0;
    next_a        = 8'd0;
    next_b        = 8'd0;

    case (state)
      IDLE:    if (go) next_state = P_MUL;
      P_MUL:   if (alu_ack || timeout) next_state = P_APPLY;
      P_APPLY: next_state = (ai_hp_new == 8'd0) ? VICTORY : A_MUL;
      A_MUL:   if (alu_ack || timeout) next_state = A_APPLY;
      A_APPLY: next_state = (player_hp_new == 8'd0) ? LOSS : IDLE;
      VICTORY: if (go) next_state = IDLE;
      LOSS:    if (go) next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Operands are computed one cycle ahead so the ALU port comes straight from flops.
    if (next_state == P_MUL) begin
      next_req = 1'b1;
      next_a   = power((state == IDLE) ? player_move : p_move);
      next_b   = (state == IDLE) ? player_atk : p_atk;
    end else if (next_state == A_MUL) begin
      next_req = 1'b1;
      next_a   = power(a_move);
      next_b   = a_atk;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_req   <= 1'b0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      turn_done <= 1'b0;
      p_move    <= 2'd0;
      a_move    <= 2'd0;
      p_atk     <= 8'd0;
      a_atk     <= 8'd0;
      dmg       <= 8'd0;
      player_hp <= HP_INIT;
      ai_hp     <= HP_INIT;
    end else begin
      alu_req   <= next_req;
      alu_a     <= next_a;
      alu_b     <= next_b;
      turn_done <= (state == A_APPLY) && (next_state == IDLE);
      case (state)
        IDLE: begin
          if (go) begin
            p_move <= player_move;
            a_move <= ai_move;
            p_atk  <= player_atk;
            a_atk  <= ai_atk;
          end
        end
        P_MUL, A_MUL: begin
          if (alu_ack)      dmg <= dmg_sat;
          else if (timeout) dmg <= 8'd0;
        end
        P_APPLY: ai_hp     <= ai_hp_new;
        A_APPLY: player_hp <= player_hp_new;
        VICTORY, LOSS: begin
          if (go) begin
            player_hp <= HP_INIT;
            ai_hp     <= HP_INIT;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BATTLE_ALU_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // wd_cnt holds the number of req cycles already spent without an ack.
  assign timeout     = in_mul && !alu_ack && (wd_cnt == 16'(TIMEOUT_CYC - 1));
  assign unused_bits = ^alu_result[2:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt  <= 16'd0;
      alu_err <= 1'b0;
    end else begin
      if (in_mul && (next_state == state)) wd_cnt <= wd_cnt + 16'd1;
      else                                  wd_cnt <= 16'd0;
      if (timeout) alu_err <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign alu_err     = 1'b0;
  assign unused_bits = ^{alu_result[2:0], TIMEOUT_CYC[0]};
`endif

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Randomized scoreboard bench for battle_turn_ctrl with an ALU responder and a turn-level reference model.
`timescale 1ns/1ps
module tb_battle_turn_ctrl;

  localparam int MAX_HP      = 100;
  localparam int TIMEOUT_CYC = 16;
  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_VIC  = 2'd1;
  localparam logic [1:0] K_LOSS = 2'd2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  player_move = 2'd0;
  logic [1:0]  ai_move = 2'd0;
  logic [7:0]  player_atk = 8'd0;
  logic [7:0]  ai_atk = 8'd0;
  logic        alu_req, alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_ack = 1'b0;
  logic [15:0] alu_result = 16'd0;
  logic [7:0]  player_hp, ai_hp;
  logic        busy, turn_done, victory, loss, alu_err;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  battle_turn_ctrl #(.MAX_HP(MAX_HP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .resetn(resetn), .go(go),
    .player_move(player_move), .ai_move(ai_move),
    .player_atk(player_atk), .ai_atk(ai_atk),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_ack(alu_ack), .alu_result(alu_result),
    .player_hp(player_hp), .ai_hp(ai_hp), .busy(busy),
    .turn_done(turn_done), .victory(victory), .loss(loss),
    .alu_err(alu_err), .fsm_state(fsm_state)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [17:0] exp_q[$];
  logic [15:0] op_q[$];
  int ack_wait = 0;
  int req_rise = 0;
  int m_php = MAX_HP;
  int m_ahp = MAX_HP;
  logic m_err = 1'b0;
  int pow_tab[4] = '{4, 6, 8, 12};
  logic prev_vic = 1'b0;
  logic prev_loss = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // ALU responder: checks operands against the expected-operation queue, acks after ack_wait cycles.
  initial begin : alu_model
    int cyc;
    logic [15:0] e;
    logic [7:0] hold_a, hold_b;
    logic stable;
    cyc = 0;
    stable = 1'b1;
    hold_a = 8'd0;
    hold_b = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (alu_req === 1'b1) begin
        if (cyc == 0) begin
          req_rise++;
          hold_a = alu_a;
          hold_b = alu_b;
          stable = (alu_op === 1'b1);
          chk("alu_req_expected", op_q.size() != 0, 1);
          if (op_q.size() != 0) begin
            e = op_q.pop_front();
            chk("alu_operands", {alu_a, alu_b}, e);
          end
        end else if (alu_a !== hold_a || alu_b !== hold_b || alu_op !== 1'b1) begin
          stable = 1'b0;
        end
        if (cyc >= ack_wait) begin
          alu_ack = 1'b1;
          alu_result = {8'd0, alu_a} * {8'd0, alu_b};
        end else begin
          alu_ack = 1'b0;
          alu_result = 16'($urandom);
        end
        cyc++;
      end else begin
        if (cyc > 0) begin
          chk("alu_hold_stable", stable, 1);
          cyc = 0;
        end
        chk("alu_op_idle", alu_op, 0);
        alu_ack = 1'($urandom_range(0, 1));
        alu_result = 16'($urandom);
      end
    end
  end

  // Monitor: every turn completion or knockout pops one expected record.
  always @(negedge clk) begin : monitor
    logic [1:0] kind;
    logic [17:0] e;
    if (resetn) begin
      if (turn_done || (victory && !prev_vic) || (loss && !prev_loss)) begin
        kind = turn_done ? K_DONE : (victory ? K_VIC : K_LOSS);
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("turn_result", {kind, player_hp, ai_hp}, e);
        end
      end
    end
    prev_vic = victory;
    prev_loss = loss;
  end

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the first non-busy cycle.
  task automatic do_turn(input logic [1:0] pm, input logic [1:0] am,
                         input logic [7:0] pa, input logic [7:0] aa,
                         input int w, input bit noise);
    int pd, ad, new_a, new_p, nb, exp_busy, wcyc;
    bit to;
    to = 1'b0;
`ifdef BATTLE_ALU_TIMEOUT_EN
    to = (w >= TIMEOUT_CYC);
`endif
    ack_wait = w;
    wcyc = to ? TIMEOUT_CYC : w + 1;
    pd = to ? 0 : sat255(pow_tab[pm] * pa / 8);
    new_a = (m_ahp > pd) ? m_ahp - pd : 0;
    op_q.push_back({8'(pow_tab[pm]), pa});
    if (new_a == 0) begin
      new_p = m_php;
      exp_q.push_back({K_VIC, 8'(new_p), 8'd0});
      exp_busy = wcyc + 1;
    end else begin
      op_q.push_back({8'(pow_tab[am]), aa});
      ad = to ? 0 : sat255(pow_tab[am] * aa / 8);
      new_p = (m_php > ad) ? m_php - ad : 0;
      exp_q.push_back({(new_p == 0) ? K_LOSS : K_DONE, 8'(new_p), 8'(new_a)});
      exp_busy = 2 * wcyc + 2;
    end
    if (to) m_err = 1'b1;

    player_move = pm; ai_move = am; player_atk = pa; ai_atk = aa;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    chk("req_after_go", alu_req, 1);
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      if (noise) begin
        go = 1'($urandom_range(0, 1));
        player_move = 2'($urandom_range(0, 3));
        ai_move = 2'($urandom_range(0, 3));
        player_atk = 8'($urandom_range(0, 255));
        ai_atk = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
    end
    go = 1'b0;
    chk("busy_cycles", nb, exp_busy);
    m_php = new_p;
    m_ahp = new_a;
  endtask

  task automatic restart();
    chk("knocked_out", victory | loss, 1);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    chk("restart_player_hp", player_hp, MAX_HP);
    chk("restart_ai_hp", ai_hp, MAX_HP);
    chk("restart_idle", {busy, victory, loss}, 0);
    m_php = MAX_HP;
    m_ahp = MAX_HP;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    m_php = MAX_HP;
    m_ahp = MAX_HP;
    m_err = 1'b0;
    exp_q.delete();
    op_q.delete();
  endtask

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    int start, n;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("reset_player_hp", player_hp, MAX_HP);
    chk("reset_ai_hp", ai_hp, MAX_HP);
    chk("reset_alu_port", {alu_req, alu_op, alu_a, alu_b}, 0);
    chk("reset_status", {busy, turn_done, victory, loss, alu_err}, 0);

    // Basic turn: 12*16/8 = 24, 4*8/8 = 4
    do_turn(2'd3, 2'd0, 8'd16, 8'd8, 0, 1'b0);
    chk("basic_ai_hp", ai_hp, 76);
    chk("basic_player_hp", player_hp, 96);

    // Saturated player hit knocks out the AI; no AI multiply follows
    pulse_reset();
    start = req_rise;
    do_turn(2'd3, 2'd2, 8'd255, 8'd200, 0, 1'b0);
    chk("victory_single_req", req_rise - start, 1);
    chk("victory_flag", victory, 1);
    restart();

    // Zero player damage, saturated AI hit
    do_turn(2'd0, 2'd3, 8'd1, 8'd255, 0, 1'b0);
    chk("loss_flag", loss, 1);
    restart();

    // Wait-state handshake with noisy inputs and dropped go pulses
    do_turn(2'd3, 2'd0, 8'd16, 8'd8, 5, 1'b1);
    chk("wait_ai_hp", ai_hp, 76);
    chk("wait_player_hp", player_hp, 96);

    // Reset while the AI multiply is pending
    pulse_reset();
    ack_wait = 3;
    start = req_rise;
    op_q.push_back({8'd4, 8'd1});
    op_q.push_back({8'd8, 8'd10});
    player_move = 2'd0; player_atk = 8'd1; ai_move = 2'd2; ai_atk = 8'd10;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    while (req_rise < start + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_ai_mul", req_rise - start, 2);
    pulse_reset();
    chk("midreset_alu_req", alu_req, 0);
    chk("midreset_hp", {player_hp, ai_hp}, {8'(MAX_HP), 8'(MAX_HP)});
    chk("midreset_busy", busy, 0);

    // Randomized games
    for (int t = 0; t < 40; t++) begin
      do_turn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 80)), 8'($urandom_range(0, 80)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (m_php == 0 || m_ahp == 0) restart();
    end

`ifdef BATTLE_ALU_TIMEOUT_EN
    // Never-acked multiplies time out with zero damage
    do_turn(2'd1, 2'd2, 8'd50, 8'd50, 1000, 1'b0);
    chk("watchdog_hp", {player_hp, ai_hp}, {8'(m_php), 8'(m_ahp)});
`endif
    chk("alu_err_state", alu_err, m_err);

    repeat (4) @(posedge clk);
    #1;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("op_queue_drained", op_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
